// File: rtl/safe_pkg.sv
// Shared definitions for the safe combination logic.
// Holds the sequencer state encoding and the step index constants used for sel.
package safe_pkg;

    typedef enum logic [2:0] {
        STEP0   = 3'd0,
        STEP1   = 3'd1,
        STEP2   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    localparam logic [1:0] SEL_STEP0 = 2'd0;
    localparam logic [1:0] SEL_STEP1 = 2'd1;
    localparam logic [1:0] SEL_STEP2 = 2'd2;

    function automatic logic [1:0] sel_of(input state_t s);
        case (s)
            STEP1:   return SEL_STEP1;
            STEP2:   return SEL_STEP2;
            default: return SEL_STEP0;
        endcase
    endfunction

endpackage

// File: rtl/safe_timer.sv
// Loadable 32-bit down-counter shared by the OPEN and LOCKOUT windows.
// Ports: clk, rst (sync, high), load/load_val in; value, zero out.
module safe_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] value,
    output logic        zero
);

    logic [31:0] r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= 32'd0;
        end else if (load) begin
            r_value <= load_val;
        end else if (r_value != 32'd0) begin
            r_value <= r_value - 32'd1;
        end
    end

    assign value = r_value;
    assign zero  = (r_value == 32'd0);

endmodule

// File: rtl/code_sequencer.sv
// Three-step combination sequencer with fail counting and timed lockout.
// Ports: clk, rst, enter, lock, eq in; sel, unlocked, locked_out, step_ok, err, fails out.
module code_sequencer
    import safe_pkg::*;
#(
    parameter int OPEN_CYCLES    = 50_000_000,
    parameter int LOCKOUT_CYCLES = 250_000_000,
    parameter int MAX_FAILS      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter,
    input  logic       lock,
    input  logic       eq,
    output logic [1:0] sel,
    output logic       unlocked,
    output logic       locked_out,
    output logic       step_ok,
    output logic       err,
    output logic [1:0] fails
);

    localparam int              FW      = $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0]   MAX_F   = FW'(MAX_FAILS);
    localparam logic [31:0]     OPEN_LD = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0]     LOCK_LD = 32'(LOCKOUT_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_enter_q;
    logic          r_rst_q;
    logic [FW-1:0] r_fail;
    logic [FW-1:0] w_fail_next;
    logic [FW-1:0] w_inc;
    logic [1:0]    r_sel;
    logic [1:0]    r_fails;
    logic [1:0]    w_fails_sat;
    logic          r_unlocked;
    logic          r_locked_out;
    logic          r_step_ok;
    logic          r_err;
    logic          w_event;
    logic          w_ok;
    logic          w_err;
    logic          w_bad;
    logic          w_load;
    logic [31:0]   w_load_val;
    logic [31:0]   w_tval;
    logic          w_tzero;
    logic          w_expired;

    safe_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .value    (w_tval),
        .zero     (w_tzero)
    );

    assign w_expired = w_tzero & (w_tval == 32'd0);

    // The first cycle after reset is masked so a held enter is not an event.
    assign w_event = enter & ~r_enter_q & ~r_rst_q;

    // Only computed in STEP states, where r_fail < MAX_FAILS, so no wrap.
    assign w_inc = r_fail + 1'b1;

    assign w_fails_sat = (32'(w_fail_next) > 32'd3) ? 2'd3 : 2'(w_fail_next);

    always_comb begin
        w_next      = r_state;
        w_fail_next = r_fail;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_bad       = 1'b0;
        w_load      = 1'b0;
        w_load_val  = 32'd0;
        unique case (r_state)
            STEP0: begin
                if (w_event && !lock) begin
                    if (eq) begin
                        w_next = STEP1;
                        w_ok   = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            STEP1: begin
                if (lock) begin
                    w_next = STEP0;
                end else if (w_event) begin
                    if (eq) begin
                        w_next = STEP2;
                        w_ok   = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            STEP2: begin
                if (lock) begin
                    w_next = STEP0;
                end else if (w_event) begin
                    if (eq) begin
                        w_next      = OPEN;
                        w_fail_next = '0;
                        w_load      = 1'b1;
                        w_load_val  = OPEN_LD;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (lock || w_expired) begin
                    w_next = STEP0;
                end
            end
            LOCKOUT: begin
                if (w_expired) begin
                    w_next      = STEP0;
                    w_fail_next = '0;
                end
            end
            default: begin
                w_next = STEP0;
            end
        endcase
        if (w_bad) begin
            w_err       = 1'b1;
            w_fail_next = w_inc;
            if (w_inc == MAX_F) begin
                w_next     = LOCKOUT;
                w_load     = 1'b1;
                w_load_val = LOCK_LD;
            end else begin
                w_next = STEP0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= STEP0;
            r_enter_q    <= 1'b0;
            r_rst_q      <= 1'b1;
            r_fail       <= '0;
            r_sel        <= SEL_STEP0;
            r_unlocked   <= 1'b0;
            r_locked_out <= 1'b0;
            r_step_ok    <= 1'b0;
            r_err        <= 1'b0;
            r_fails      <= 2'd0;
        end else begin
            r_state      <= w_next;
            r_enter_q    <= enter;
            r_rst_q      <= 1'b0;
            r_fail       <= w_fail_next;
            r_sel        <= sel_of(w_next);
            r_unlocked   <= (w_next == OPEN);
            r_locked_out <= (w_next == LOCKOUT);
            r_step_ok    <= w_ok;
            r_err        <= w_err;
            r_fails      <= w_fails_sat;
        end
    end

    assign sel        = r_sel;
    assign unlocked   = r_unlocked;
    assign locked_out = r_locked_out;
    assign step_ok    = r_step_ok;
    assign err        = r_err;
    assign fails      = r_fails;

endmodule

// File: tb/tb_code_sequencer.sv
// Bench for code_sequencer: behavioural model plus directed and random stimulus.
// Combination held by the bench comparator is 10, 05, 15.
module tb_code_sequencer;

    localparam int OC = 8;
    localparam int LC = 16;
    localparam int MF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enter = 1'b0;
    logic       lock = 1'b0;
    logic       eq;
    int         code = 0;
    logic [1:0] sel;
    logic       unlocked;
    logic       locked_out;
    logic       step_ok;
    logic       err;
    logic [1:0] fails;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    int n_ok  = 0;
    int n_err = 0;
    int n_unl = 0;
    int n_lo  = 0;
    int b_ok, b_err, b_unl, b_lo;

    // model state: remaining open / lockout cycles, current step, fail count
    int m_step = 0;
    int m_open = 0;
    int m_lock = 0;
    int m_fails = 0;
    bit m_prev = 1'b1;
    bit m_ok = 1'b0;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    function automatic int combo(input int s);
        case (s)
            0:       return 10;
            1:       return 5;
            2:       return 15;
            default: return -1;
        endcase
    endfunction

    assign eq = (code == combo(int'(sel)));

    code_sequencer #(
        .OPEN_CYCLES    (OC),
        .LOCKOUT_CYCLES (LC),
        .MAX_FAILS      (MF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enter      (enter),
        .lock       (lock),
        .eq         (eq),
        .sel        (sel),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .step_ok    (step_ok),
        .err        (err),
        .fails      (fails)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit ev;
        if (rst) begin
            m_step  = 0;
            m_open  = 0;
            m_lock  = 0;
            m_fails = 0;
            m_prev  = 1'b1;
            m_ok    = 1'b0;
            m_err   = 1'b0;
        end else begin
            ev     = enter && !m_prev;
            m_prev = enter;
            m_ok   = 1'b0;
            m_err  = 1'b0;
            if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) m_fails = 0;
            end else if (m_open > 0) begin
                if (lock) m_open = 0;
                else m_open--;
            end else if (lock) begin
                m_step = 0;
            end else if (ev) begin
                if (code == combo(m_step)) begin
                    if (m_step < 2) begin
                        m_step++;
                        m_ok = 1'b1;
                    end else begin
                        m_step  = 0;
                        m_open  = OC;
                        m_fails = 0;
                    end
                end else begin
                    m_err = 1'b1;
                    m_step = 0;
                    m_fails++;
                    if (m_fails == MF) m_lock = LC;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sel", int'(sel), (m_open > 0 || m_lock > 0) ? 0 : m_step);
            chk("unlocked", int'(unlocked), int'(m_open > 0));
            chk("locked_out", int'(locked_out), int'(m_lock > 0));
            chk("step_ok", int'(step_ok), int'(m_ok));
            chk("err", int'(err), int'(m_err));
            chk("fails", int'(fails), (m_fails > 3) ? 3 : m_fails);
        end
        if (step_ok === 1'b1) n_ok++;
        if (err === 1'b1) n_err++;
        if (unlocked === 1'b1) n_unl++;
        if (locked_out === 1'b1) n_lo++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int c);
        @(negedge clk);
        code  = c;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_fails", int'(fails), 0);
        chk("rst_sel", int'(sel), 0);

        // correct code
        b_ok = n_ok;
        b_unl = n_unl;
        press(10);
        chk("s0_sel", int'(sel), 1);
        chk("s0_ok", int'(step_ok), 1);
        tick(1);
        press(5);
        chk("s1_sel", int'(sel), 2);
        press(15);
        chk("open_hi", int'(unlocked), 1);
        chk("open_sel", int'(sel), 0);
        tick(12);
        chk("ok_pulses", n_ok - b_ok, 2);
        chk("unlock_len", n_unl - b_unl, 8);

        // wrong step then recover
        press(10);
        press(6);
        chk("wrong_err", int'(err), 1);
        chk("wrong_fails", int'(fails), 1);
        chk("wrong_sel", int'(sel), 0);
        press(10);
        press(5);
        press(15);
        chk("clear_fails", int'(fails), 0);
        tick(10);

        // lockout
        b_err = n_err;
        press(99);
        press(99);
        chk("two_fails", int'(fails), 2);
        b_lo = n_lo;
        press(99);
        chk("third_err", int'(err), 1);
        chk("lo_rise", int'(locked_out), 1);
        chk("lo_fails", int'(fails), 3);
        repeat (3) begin
            press(10);
            tick(1);
        end
        chk("lo_no_err", n_err - b_err, 3);
        tick(20);
        chk("lo_len", n_lo - b_lo, 16);
        chk("lo_exit_fails", int'(fails), 0);
        chk("lo_exit", int'(locked_out), 0);

        // held enter yields a single event
        press(99);
        b_ok = n_ok;
        @(negedge clk);
        code = 10;
        enter = 1'b1;
        tick(20);
        enter = 1'b0;
        chk("hold_ok", n_ok - b_ok, 1);
        chk("hold_sel", int'(sel), 1);

        // lock beats enter in STEP1
        tick(1);
        code = 5;
        enter = 1'b1;
        lock = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        lock = 1'b0;
        chk("lockwin_sel", int'(sel), 0);
        chk("lockwin_err", int'(err), 0);
        chk("lockwin_fails", int'(fails), 1);

        // lock in OPEN on its third cycle
        press(10);
        press(5);
        b_unl = n_unl;
        press(15);
        tick(2);
        lock = 1'b1;
        @(negedge clk);
        lock = 1'b0;
        chk("open_lock", int'(unlocked), 0);
        chk("open_lock_len", n_unl - b_unl, 3);
        tick(3);

        // reset in STEP2
        press(10);
        press(5);
        chk("pre_rst_sel", int'(sel), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_sel", int'(sel), 0);
        chk("rst2_unl", int'(unlocked), 0);
        chk("rst2_lo", int'(locked_out), 0);
        chk("rst2_ok", int'(step_ok), 0);
        chk("rst2_err", int'(err), 0);
        chk("rst2_fails", int'(fails), 0);

        // reset in LOCKOUT
        press(99);
        press(99);
        press(99);
        chk("pre_rst_lo", int'(locked_out), 1);
        tick(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstl_lo", int'(locked_out), 0);
        chk("rstl_fails", int'(fails), 0);
        chk("rstl_err", int'(err), 0);

        // enter held across reset release
        code = 10;
        enter = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b_ok = n_ok;
        tick(5);
        enter = 1'b0;
        chk("rel_ok", n_ok - b_ok, 0);
        chk("rel_sel", int'(sel), 0);

        // random traffic
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) code = int'($urandom_range(99));
            else code = combo(m_step);
            enter = 1'($urandom_range(1));
            lock  = ($urandom_range(11) == 0);
            rst   = ($urandom_range(299) == 0);
        end
        @(negedge clk);
        enter = 1'b0;
        lock = 1'b0;
        rst = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
